// File: rtl/palette_encoder.sv
// rtl/palette_encoder.sv - streaming RGB-to-palette quantizer with wrapping sprite address
//
// Two-stage pipeline: stage 1 registers the Manhattan distance from the pixel
// to each of the seven palette entries; stage 2 picks the nearest entry
// (lowest index on a tie) and presents it with a sprite-memory address.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_rgb holds a pixel
//   in_ready   block can accept a pixel this cycle
//   in_rgb     pixel {R[23:16], G[15:8], B[7:0]}
//   out_valid  output fields valid
//   out_ready  downstream accepts the output this cycle
//   out_index  nearest palette index (0..6)
//   out_addr   sprite-memory write address, wraps after PIXELS-1
//   out_exact  pixel equals a palette entry
//   out_last   high with the pixel at address PIXELS-1
module palette_encoder #(
  parameter int PIXELS = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_rgb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_index,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_exact,
  output logic              out_last
);

  function automatic logic [23:0] pal_color(input int idx);
    case (idx)
      0:       pal_color = 24'hAAAAAA;
      1:       pal_color = 24'h000000;
      2:       pal_color = 24'h00FFFF;
      3:       pal_color = 24'hFFE4B5;
      4:       pal_color = 24'hD2B48C;
      5:       pal_color = 24'h00FF00;
      default: pal_color = 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    abs_diff = (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] rgb_dist(input logic [23:0] a, input logic [23:0] b);
    rgb_dist = {2'b00, abs_diff(a[23:16], b[23:16])}
             + {2'b00, abs_diff(a[15:8],  b[15:8])}
             + {2'b00, abs_diff(a[7:0],   b[7:0])};
  endfunction

  logic       adv;
  logic       s1_valid;
  logic [9:0] dist_q [7];
  logic [2:0] best_idx;
  logic [9:0] best_d;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 7; i++) begin
          dist_q[i] <= rgb_dist(in_rgb, pal_color(i));
        end
      end
    end
  end

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_idx = 3'd0;
    best_d   = dist_q[0];
    for (int i = 1; i < 7; i++) begin
      if (dist_q[i] < best_d) begin
        best_idx = 3'(i);
        best_d   = dist_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= 3'd0;
      out_exact <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_index <= best_idx;
        out_exact <= (best_d == 10'd0);
      end
    end
  end

  // Address counts retired outputs, so it stays put while a result is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_addr <= '0;
    end else if (out_valid && out_ready) begin
      if (out_addr == ADDR_W'(PIXELS - 1)) begin
        out_addr <= '0;
      end else begin
        out_addr <= out_addr + 1'b1;
      end
    end
  end

  assign out_last = out_valid && (out_addr == ADDR_W'(PIXELS - 1));

endmodule

// File: tb/tb_palette_encoder.sv
// tb/tb_palette_encoder.sv - randomized and directed bench for palette_encoder against a reference model
module tb_palette_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [23:0] in_rgb;

  logic        a_in_ready, a_out_valid, a_out_exact, a_out_last;
  logic [2:0]  a_out_index;
  logic [9:0]  a_out_addr;
  logic        b_in_ready, b_out_valid, b_out_exact, b_out_last;
  logic [2:0]  b_out_index;
  logic [1:0]  b_out_addr;

  palette_encoder #(.PIXELS(1024), .ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_rgb(in_rgb),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_index(a_out_index),
    .out_addr(a_out_addr), .out_exact(a_out_exact), .out_last(a_out_last)
  );

  palette_encoder #(.PIXELS(4), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_rgb(in_rgb),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_index(b_out_index),
    .out_addr(b_out_addr), .out_exact(b_out_exact), .out_last(b_out_last)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] palette(input int i);
    logic [23:0] p [7];
    p = '{24'hAAAAAA, 24'h000000, 24'h00FFFF, 24'hFFE4B5, 24'hD2B48C, 24'h00FF00, 24'hFFFFFF};
    return p[i];
  endfunction

  function automatic int chan_dist(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int distance(input logic [23:0] x, input logic [23:0] y);
    return chan_dist(int'(x[23:16]), int'(y[23:16]))
         + chan_dist(int'(x[15:8]),  int'(y[15:8]))
         + chan_dist(int'(x[7:0]),   int'(y[7:0]));
  endfunction

  // Nearest entry: find the smallest distance, then the first index achieving it.
  function automatic int nearest(input logic [23:0] rgb, output bit exact);
    int d [7];
    int m;
    m = 1000;
    for (int i = 0; i < 7; i++) begin
      d[i] = distance(rgb, palette(i));
      if (d[i] < m) m = d[i];
    end
    exact = (m == 0);
    for (int i = 0; i < 7; i++) begin
      if (d[i] == m) return i;
    end
    return 0;
  endfunction

  logic [23:0] q [$];
  int  addr_a, addr_b;
  bit  hist_acc [2];
  bit  hist_adv [2];
  int  hist_n;
  bit  held;
  logic [2:0] h_index;
  logic [9:0] h_addr;
  logic       h_exact, h_last;

  task automatic cycle(input logic v, input logic [23:0] rgb, input logic ordy);
    logic [23:0] px;
    int  idx;
    bit  ex;
    bit  acc;
    in_valid = v;
    in_rgb = rgb;
    out_ready = ordy;
    #1;
    check("in_ready_a", a_in_ready, !a_out_valid || ordy);
    check("in_ready_b", b_in_ready, !b_out_valid || ordy);
    check("addr_a", a_out_addr, addr_a);
    check("last_a", a_out_last, a_out_valid && (addr_a == 1023));
    if (hist_n >= 2 && hist_adv[0] && hist_adv[1])
      check("latency", a_out_valid, hist_acc[1]);
    if (held) begin
      check("hold_valid", a_out_valid, 1);
      check("hold_index", a_out_index, h_index);
      check("hold_exact", a_out_exact, h_exact);
      check("hold_addr", a_out_addr, h_addr);
      check("hold_last", a_out_last, h_last);
    end
    if (a_out_valid && ordy) begin
      if (q.size() == 0) begin
        check("spurious_out", a_out_valid, 0);
      end else begin
        px = q.pop_front();
        idx = nearest(px, ex);
        check("index_a", a_out_index, idx);
        check("exact_a", a_out_exact, ex);
        check("valid_b", b_out_valid, 1);
        check("index_b", b_out_index, idx);
        check("exact_b", b_out_exact, ex);
        check("addr_b", b_out_addr, addr_b);
        check("last_b", b_out_last, addr_b == 3);
        addr_a = (addr_a + 1) % 1024;
        addr_b = (addr_b + 1) % 4;
      end
    end
    held = a_out_valid && !ordy;
    h_index = a_out_index;
    h_exact = a_out_exact;
    h_addr = a_out_addr;
    h_last = a_out_last;
    acc = v && a_in_ready;
    if (acc) q.push_back(rgb);
    hist_acc[1] = hist_acc[0];
    hist_acc[0] = acc;
    hist_adv[1] = hist_adv[0];
    hist_adv[0] = a_in_ready;
    hist_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_rgb = 24'h0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    addr_a = 0;
    addr_b = 0;
    held = 0;
    hist_n = 0;
    #1;
    check("rst_valid", a_out_valid, 0);
    check("rst_index", a_out_index, 0);
    check("rst_exact", a_out_exact, 0);
    check("rst_addr", a_out_addr, 0);
    check("rst_last", a_out_last, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_valid_b", b_out_valid, 0);
    check("rst_addr_b", b_out_addr, 0);
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] near_tbl [5];
    rst = 1'b1;
    in_valid = 1'b0;
    in_rgb = 24'h0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) cycle(1'b1, palette(i), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 24'h0, 1'b1);

    near_tbl = '{24'h101010, 24'h00FF7F, 24'hFFE0B0, 24'h808080, 24'h555555};
    for (int i = 0; i < 5; i++) cycle(1'b1, near_tbl[i], 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 24'h0, 1'b1);

    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 24'h0, 1'b1);

    cycle(1'b1, 24'h123456, 1'b1);
    cycle(1'b1, 24'hFEDCBA, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 24'h0, 1'b1);
    cycle(1'b1, 24'h00FFFF, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 24'h0, 1'b1);

    for (int i = 0; i < 1400; i++) begin
      logic [23:0] px;
      px = ($urandom_range(0, 3) == 0) ? palette($urandom_range(0, 6)) : 24'($urandom);
      cycle($urandom_range(0, 3) != 0, px, $urandom_range(0, 4) != 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 24'h0, 1'b1);
    #1;
    check("drained", a_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
